// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned COUNT_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0]        DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush/stall/boot priority, valid flag and fetch counter.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 boot,
    input  logic [INSTR_W-1:0]   instr,
    input  logic [Width-1:0]     pc,
    output logic [INSTR_W-1:0]   InstrD,
    output logic [Width-1:0]     PCD,
    output logic [Width-1:0]     PCPlus4D,
    output logic                 ValidD,
    output logic [COUNT_W-1:0]   FetchCount
);

    logic [Width-1:0] pc_plus4;

    assign pc_plus4 = pc + Width'(4);

    // Flush outranks stall; boot cycle only ever inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            ValidD     <= 1'b0;
            FetchCount <= '0;
        end else if (flush) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (stall) begin
            InstrD   <= InstrD;
            PCD      <= PCD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else if (boot) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else begin
            InstrD     <= instr;
            PCD        <= pc;
            PCPlus4D   <= pc_plus4;
            ValidD     <= 1'b1;
            FetchCount <= FetchCount + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, boot FSM, misalignment flag
// and the IF/ID register feeding decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     Width    = 32,
    parameter logic [Width-1:0] RESET_PC = Width'(DEFAULT_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 PCSrc,
    input  logic [Width-1:0]     PCTarget,
    output logic [Width-1:0]     ImemAddr,
    output logic                 ImemEn,
    input  logic [INSTR_W-1:0]   ImemData,
    output logic [INSTR_W-1:0]   InstrD,
    output logic [Width-1:0]     PCD,
    output logic [Width-1:0]     PCPlus4D,
    output logic                 ValidD,
    output logic                 Misaligned,
    output logic [COUNT_W-1:0]   FetchCount
);

    fetch_state_t     state, state_next;
    logic [Width-1:0] pc_f, pc_next;
    logic             misalign_set;
    logic             boot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc_f       <= RESET_PC;
            Misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            pc_f       <= pc_next;
            Misaligned <= Misaligned | misalign_set;
        end
    end

    // Next-PC mux; the memory address is the next PC so ImemData tracks pc_f.
    always_comb begin
        state_next   = state;
        pc_next      = pc_f;
        ImemAddr     = pc_f;
        ImemEn       = 1'b0;
        misalign_set = 1'b0;
        boot         = 1'b0;
        case (state)
            BOOT: begin
                boot       = 1'b1;
                ImemAddr   = pc_f;
                ImemEn     = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (PCSrc) begin
                    pc_next = {PCTarget[Width-1:2], 2'b00};
                end else if (StallF) begin
                    pc_next = pc_f;
                end else begin
                    pc_next = pc_f + Width'(4);
                end
                ImemAddr     = pc_next;
                ImemEn       = !StallF || PCSrc;
                misalign_set = PCSrc && (PCTarget[1:0] != 2'b00);
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    if_id_reg #(
        .Width (Width)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush      (FlushD && !boot),
        .stall      (StallD && !boot),
        .boot       (boot),
        .instr      (ImemData),
        .pc         (pc_f),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchCount (FetchCount)
    );

endmodule
